gpio_bank_debounce: RTL

Parametrised fabric GPIO bank: the successor to the single MSS GPIO_0_BI pin, generalised to NUM_GPIO bidirectional channels. Each channel has:
- per-bit direction
- 2-flop input synchroniser
- counter-based debouncer
- rise/fall edge detection with sticky, write-1-to-clear interrupt status

Sits in the fabric beside the MSS. Its IRQ output feeds an MSS fabric interrupt for controller buttons and screen strobes.

---
 rtl/gpio_bank_debounce.sv | 98 +++++++++
 1 files changed

// File: rtl/gpio_bank_debounce.sv
// rtl/gpio_bank_debounce.sv - NUM_GPIO-channel fabric GPIO bank with debounce and sticky edge IRQs (option: GPIO_BANK_LEVEL_IRQ_EN)
module gpio_bank_debounce #(
    parameter int NUM_GPIO        = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic                FAB_CLK,
    input  logic                FAB_RST,
    inout  wire  [NUM_GPIO-1:0] GPIO_BI,
    input  logic [NUM_GPIO-1:0] DIR_OE,
    input  logic [NUM_GPIO-1:0] DOUT,
    output logic [NUM_GPIO-1:0] DIN,
    input  logic [NUM_GPIO-1:0] IRQ_RISE_EN,
    input  logic [NUM_GPIO-1:0] IRQ_FALL_EN,
    input  logic [NUM_GPIO-1:0] IRQ_CLR,
`ifdef GPIO_BANK_LEVEL_IRQ_EN
    input  logic [NUM_GPIO-1:0] IRQ_LEVEL,
`endif
    output logic [NUM_GPIO-1:0] IRQ_STATUS,
    output logic                IRQ
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_GPIO-1:0] sync1_q, sync2_q;
    logic [NUM_GPIO-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q [NUM_GPIO];
    logic [CNT_W-1:0]    cnt_d [NUM_GPIO];
    logic [NUM_GPIO-1:0] update;
    logic [NUM_GPIO-1:0] edge_set;
    logic [NUM_GPIO-1:0] set;
    logic [NUM_GPIO-1:0] status_q, status_d;
    logic                irq_q, irq_d;

    // Pad drivers: each bit is either driven from DOUT or released
    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pad
        assign GPIO_BI[g] = DIR_OE[g] ? DOUT[g] : 1'bz;
    end

    // Per-channel debounce: a differing sync2 value must persist for DEBOUNCE_CYCLES cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        update   = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TERM) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                update[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Event generation and sticky status; a new set beats a simultaneous clear
    always_comb begin
        edge_set = update & ((sync2_q & IRQ_RISE_EN) | (~sync2_q & IRQ_FALL_EN));
`ifdef GPIO_BANK_LEVEL_IRQ_EN
        set = (~IRQ_LEVEL & edge_set)
            | (IRQ_LEVEL & ((stable_q & IRQ_RISE_EN) | (~stable_q & IRQ_FALL_EN)));
`else
        set = edge_set;
`endif
        status_d = set | (status_q & ~IRQ_CLR);
        irq_d    = |status_q;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= GPIO_BI;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            status_q <= status_d;
            irq_q    <= irq_d;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign DIN        = stable_q;
    assign IRQ_STATUS = status_q;
    assign IRQ        = irq_q;

endmodule
